// File: rtl/register_file_pkg.sv
// Shared MIPS register-file constants: geometry, special register indices
// and the default reset values for the global and stack pointers.
package register_file_pkg;

  localparam int NUM_REGS = 32;
  localparam int IDX_W    = 5;

  localparam int GP_IDX = 28;
  localparam int SP_IDX = 29;

  localparam logic [31:0] GP_RST_DEFAULT = 32'h1000_8000;
  localparam logic [31:0] SP_RST_DEFAULT = 32'h7FFF_EFFC;

endpackage : register_file_pkg

// File: rtl/register_file_register.sv
// Single N-bit architectural register with write enable and an
// asynchronous active-low reset to a per-instance reset value.
module Register #(
  parameter int            N        = 32,
  parameter logic [N-1:0]  rstValue = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] DataInput,
  output logic [N-1:0] DataOutput
);

  // Storage: reset forces rstValue immediately; otherwise load on enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DataOutput <= rstValue;
    end else if (enable) begin
      DataOutput <= DataInput;
    end
  end

endmodule : Register

// File: rtl/register_file.sv
// MIPS integer register file: 31 writable registers plus hard-wired $zero,
// two combinational read ports and a write-through bypass so that a value
// being written back is visible to decode in the same cycle.
module register_file
  import register_file_pkg::*;
#(
  parameter int           N      = 32,
  parameter logic [N-1:0] SP_RST = N'(SP_RST_DEFAULT),
  parameter logic [N-1:0] GP_RST = N'(GP_RST_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [IDX_W-1:0] WriteRegister,
  input  logic [N-1:0]     WriteData,
  input  logic [IDX_W-1:0] ReadRegister1,
  input  logic [IDX_W-1:0] ReadRegister2,
  output logic [N-1:0]     ReadData1,
  output logic [N-1:0]     ReadData2
);

  // Register contents indexed by register number; entry 0 is a constant.
  logic [NUM_REGS-1:0][N-1:0] regs;
  // One-hot write enables; index 0 has no storage and hence no enable.
  logic [NUM_REGS-1:1]        we;

  logic bypass1;
  logic bypass2;

  assign regs[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    localparam logic [N-1:0] RST_V = (i == GP_IDX) ? GP_RST :
                                     (i == SP_IDX) ? SP_RST : '0;

    // Each enable compares against its own index, so at most one is set.
    assign we[i] = RegWrite && (WriteRegister == IDX_W'(i));

    Register #(
      .N        (N),
      .rstValue (RST_V)
    ) u_reg (
      .clk        (clk),
      .reset      (reset),
      .enable     (we[i]),
      .DataInput  (WriteData),
      .DataOutput (regs[i])
    );
  end

  // Bypass only for a real write to a non-zero index matching the read index.
  always_comb begin
    bypass1 = 1'b0;
    bypass2 = 1'b0;
    if (RegWrite && (WriteRegister != '0)) begin
      bypass1 = (WriteRegister == ReadRegister1);
      bypass2 = (WriteRegister == ReadRegister2);
    end
  end

  // Read port 1: forwarded write data or the selected register.
  always_comb begin
    ReadData1 = regs[ReadRegister1];
    if (bypass1) begin
      ReadData1 = WriteData;
    end
  end

  // Read port 2: forwarded write data or the selected register.
  always_comb begin
    ReadData2 = regs[ReadRegister2];
    if (bypass2) begin
      ReadData2 = WriteData;
    end
  end

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed testbench for register_file: reset values, write/read, $zero,
// bypass, asynchronous reset, and a full two-port sweep.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int vectors     = 0;
  int miscompares = 0;

  register_file dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are read 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    #1;
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    logic [31:0] k;
    k = 32'h0101_0101;
    return (i == 0) ? 32'h0 : k * 32'(i);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;

    // Reset values
    tick();
    tick();
    rd(5'd28, 5'd29);
    chk("rst_r28", ReadData1, 32'h1000_8000);
    chk("rst_r29", ReadData2, 32'h7FFF_EFFC);
    rd(5'd5, 5'd31);
    chk("rst_r5", ReadData1, 32'h0);
    chk("rst_r31", ReadData2, 32'h0);
    rd(5'd0, 5'd28);
    chk("rst_r0", ReadData1, 32'h0);
    chk("rst_r28_p2", ReadData2, 32'h1000_8000);

    // First edge after deassertion performs a write
    reset         = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd8;
    WriteData     = 32'hDEAD_BEEF;
    tick();
    RegWrite = 1'b0;
    rd(5'd8, 5'd9);
    chk("wr_r8", ReadData1, 32'hDEAD_BEEF);
    chk("wr_r9_untouched", ReadData2, 32'h0);
    rd(5'd9, 5'd8);
    chk("wr_r8_p2", ReadData2, 32'hDEAD_BEEF);

    // RegWrite low: no change
    WriteRegister = 5'd10;
    WriteData     = 32'hCAFE_F00D;
    tick();
    rd(5'd10, 5'd8);
    chk("nowe_r10", ReadData1, 32'h0);
    chk("nowe_r8", ReadData2, 32'hDEAD_BEEF);

    // $zero: write discarded, no bypass
    RegWrite      = 1'b1;
    WriteRegister = 5'd0;
    WriteData     = 32'hFFFF_FFFF;
    rd(5'd0, 5'd0);
    chk("zero_pre_p1", ReadData1, 32'h0);
    chk("zero_pre_p2", ReadData2, 32'h0);
    tick();
    chk("zero_post_p1", ReadData1, 32'h0);
    chk("zero_post_p2", ReadData2, 32'h0);
    RegWrite = 1'b0;

    // Bypass before the edge, then withdrawn
    RegWrite      = 1'b1;
    WriteRegister = 5'd17;
    WriteData     = 32'h1234_5678;
    rd(5'd8, 5'd17);
    chk("byp_p2", ReadData2, 32'h1234_5678);
    chk("byp_p1_other", ReadData1, 32'hDEAD_BEEF);
    rd(5'd17, 5'd17);
    chk("byp_both_p1", ReadData1, 32'h1234_5678);
    chk("byp_both_p2", ReadData2, 32'h1234_5678);
    RegWrite = 1'b0;
    #1;
    chk("nobyp_p2_old", ReadData2, 32'h0);

    // Asynchronous reset mid-cycle restores $sp without an edge
    RegWrite      = 1'b1;
    WriteRegister = 5'd29;
    WriteData     = 32'hA5A5_A5A5;
    tick();
    RegWrite = 1'b0;
    rd(5'd29, 5'd8);
    chk("sp_written", ReadData1, 32'hA5A5_A5A5);
    #1;
    reset = 1'b0;
    #1;
    chk("async_sp", ReadData1, 32'h7FFF_EFFC);
    chk("async_r8", ReadData2, 32'h0);
    reset = 1'b1;
    #1;

    // Reset held across an edge beats a pending write
    tick();
    reset         = 1'b0;
    RegWrite      = 1'b1;
    WriteRegister = 5'd5;
    WriteData     = 32'h5555_AAAA;
    tick();
    RegWrite = 1'b0;
    rd(5'd5, 5'd28);
    chk("rst_wins_r5", ReadData1, 32'h0);
    chk("rst_wins_r28", ReadData2, 32'h1000_8000);
    reset = 1'b1;
    #1;

    // Sweep: write every index, then read every pair on both ports
    RegWrite = 1'b1;
    for (int i = 1; i < 32; i++) begin
      WriteRegister = 5'(i);
      WriteData     = sweep_val(i);
      tick();
    end
    RegWrite = 1'b0;
    #1;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        rd(5'(a), 5'(b));
        chk($sformatf("sweep_p1[%0d]", a), ReadData1, sweep_val(a));
        chk($sformatf("sweep_p2[%0d]", b), ReadData2, sweep_val(b));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter N, default 32, data width of every register and data port.
REQ-002 Parameter SP_RST, default 32'h7FFF_EFFC, reset value of register 29 ($sp).
REQ-003 Parameter GP_RST, default 32'h1000_8000, reset value of register 28 ($gp).
REQ-004 clk  input  1  single clock; all register updates occur on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 forces every register to its reset value immediately.
REQ-006 RegWrite  input  1  write enable from the write-back stage.
REQ-007 WriteRegister  input  5  destination register index.
REQ-008 WriteData  input  N  value to write.
REQ-009 ReadRegister1  input  5  source index for port 1.
REQ-010 ReadRegister2  input  5  source index for port 2.
REQ-011 ReadData1  output  N  contents of ReadRegister1, combinational.
REQ-012 ReadData2  output  N  contents of ReadRegister2, combinational.

Function
REQ-013 The block SHALL hold 32 registers of N bits, indices 0..31.
REQ-014 Register 0 SHALL always read as 0; writes to index 0 SHALL be discarded; no storage element for index 0.
REQ-015 On a rising clk edge with reset=1 and RegWrite=1, the register at WriteRegister (1..31) SHALL load WriteData; all other registers SHALL hold.
REQ-016 With RegWrite=0 no register SHALL change, regardless of WriteRegister/WriteData.
REQ-017 Write decode SHALL be one-hot: exactly one register enabled when RegWrite=1 and WriteRegister!=0, none otherwise.
REQ-018 Read ports SHALL be independent, combinational 32:1 selects; ReadRegister1 == ReadRegister2 is legal and both ports return the same value.
REQ-019 Write-through bypass: if RegWrite=1, WriteRegister!=0 and WriteRegister equals a read index, that port SHALL output WriteData in the same cycle (resolves WB->ID hazard, zero-cycle latency).
REQ-020 Bypass SHALL NOT apply when WriteRegister=0; reads of index 0 return 0 even while a write to 0 is requested.
REQ-021 Without bypass, a written value SHALL be visible on read ports from the cycle after the write edge (one-cycle write latency).
REQ-022 No arithmetic; data passes unmodified, full N bits, no truncation or sign extension.

Reset
REQ-023 While reset=0, registers 1..27, 30, 31 SHALL be 0, register 28 SHALL be GP_RST, register 29 SHALL be SP_RST, independent of clk.
REQ-024 Reset asserted mid-write SHALL win: the pending write is lost and the reset value held.
REQ-025 During reset, read ports SHALL reflect reset values (bypass still active per REQ-019; pipeline holds RegWrite=0 during reset).
REQ-026 Deassertion of reset SHALL allow writes from the first rising clk edge with reset=1.

Structure
REQ-027 Register count (32), index width (5), $sp/$gp indices and default reset constants SHALL live in the shared MIPS package.
REQ-028 One sub-module is natural: Register (N, rstValue, clk/reset/enable/DataInput/DataOutput), instantiated 31 times with per-index rstValue.
REQ-029 Decoder, read multiplexers and bypass compare SHALL be combinational logic in register_file itself.

Verification
REQ-030 Reset: reset=0 for 2 cycles -> read 28 = 32'h1000_8000, 29 = 32'h7FFF_EFFC, 5 = 0, 31 = 0.
REQ-031 Write/read: RegWrite=1, WR=8, WD=32'hDEAD_BEEF at edge; next cycle ReadRegister1=8 -> ReadData1=32'hDEAD_BEEF; register 9 remains 0.
REQ-032 Zero register: write 32'hFFFF_FFFF to index 0 -> ReadData1/2 at index 0 = 0 before and after edge.
REQ-033 Bypass: RegWrite=1, WR=17, WD=32'h1234_5678, ReadRegister2=17 same cycle -> ReadData2=32'h1234_5678 before the edge; with RegWrite=0 -> old value.
REQ-034 Reset mid-operation: write 32'hA5A5_A5A5 to 29, then reset pulse low between edges -> 29 reads 32'h7FFF_EFFC immediately, no clk edge required.
REQ-035 Exhaustive sweep: write index i value i*32'h0101_0101 for i=1..31, then read all pairs on both ports -> every value matches, index 0 = 0.
